// File: rtl/cpu_mem_pkg.sv
// Shared types and address helpers for the CPU-side SRAM responder.
// Addresses are MIPS-style virtual; kseg0/kseg1 fold onto the same physical window.
package cpu_mem_pkg;

    localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;
    localparam int          WORD_BYTES = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    // Source of a port's visible read data: the bank output register or forced zero.
    typedef enum logic {
        RD_ZERO = 1'b0,
        RD_MEM  = 1'b1
    } rd_src_e;

    function automatic word_t fold_addr(input word_t addr);
        return addr & KSEG_MASK;
    endfunction

endpackage

// File: rtl/sram_dp_bank.sv
// Dual-port word array: port A read-only, port B read/write with byte enables.
// Both ports are read-first and have registered outputs that hold while disabled.
module sram_dp_bank
    import cpu_mem_pkg::*;
#(
    parameter int    ADDR_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  a_en_i,
    input  logic [ADDR_W-1:0]     a_addr_i,
    output logic [31:0]           a_rdata_o,
    input  logic                  b_en_i,
    input  logic [WORD_BYTES-1:0] b_we_i,
    input  logic [ADDR_W-1:0]     b_addr_i,
    input  logic [31:0]           b_wdata_i,
    output logic [31:0]           b_rdata_o
);

    word_t mem [0:(1<<ADDR_W)-1];
    word_t a_rdata_q;
    word_t b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_en_i) begin
            a_rdata_q <= mem[a_addr_i];
        end
    end

    // Output register samples the pre-write word, giving read-first on port B.
    always_ff @(posedge clk) begin
        if (b_en_i) begin
            b_rdata_q <= mem[b_addr_i];
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (b_we_i[i]) begin
                    mem[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the CPU inst/data SRAM ports over one shared dual-port array.
// Folds kseg addresses, rejects illegal accesses with zero data, and counts them.
module cpu_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] PHYS_BASE = 32'h1FC0_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_en,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        err_sticky,
    output logic [15:0] err_count
);

    word_t   inst_off;
    word_t   data_off;
    logic    inst_in_range;
    logic    data_in_range;
    logic    inst_bad;
    logic    data_bad;
    logic    inst_ok;
    logic    data_ok;

    rd_src_e     inst_src_q, inst_src_d;
    rd_src_e     data_src_q, data_src_d;
    logic        err_sticky_q, err_sticky_d;
    logic [15:0] err_count_q, err_count_d;
    logic [16:0] err_sum;

    word_t bank_a_rdata;
    word_t bank_b_rdata;
    be_t   bank_b_we;

    logic  unused_inst_wdata;
    assign unused_inst_wdata = ^inst_wdata;

    assign inst_off = fold_addr(inst_addr) - PHYS_BASE;
    assign data_off = fold_addr(data_addr) - PHYS_BASE;

    // Offsets below PHYS_BASE wrap to huge values and therefore fail the range test too.
    assign inst_in_range = (inst_off >> (ADDR_W + 2)) == 32'd0;
    assign data_in_range = (data_off >> (ADDR_W + 2)) == 32'd0;

    assign inst_bad = inst_en && (!inst_in_range || (inst_off[1:0] != 2'b00) || (inst_wen != 4'h0));
    assign data_bad = data_en && (!data_in_range || (data_off[1:0] != 2'b00));
    assign inst_ok  = inst_en && !inst_bad;
    assign data_ok  = data_en && !data_bad;

    // Gating with resetn drops any store that lands on an edge while reset is held.
    assign bank_b_we = (data_ok && resetn) ? data_wen : 4'h0;

    sram_dp_bank #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk       (clk),
        .a_en_i    (inst_ok && resetn),
        .a_addr_i  (inst_off[ADDR_W+1:2]),
        .a_rdata_o (bank_a_rdata),
        .b_en_i    (data_ok && resetn),
        .b_we_i    (bank_b_we),
        .b_addr_i  (data_off[ADDR_W+1:2]),
        .b_wdata_i (data_wdata),
        .b_rdata_o (bank_b_rdata)
    );

    always_comb begin
        inst_src_d   = inst_src_q;
        data_src_d   = data_src_q;
        err_sticky_d = err_sticky_q | inst_bad | data_bad;
        err_sum      = {1'b0, err_count_q} + {16'd0, inst_bad} + {16'd0, data_bad};
        err_count_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (inst_en) begin
            inst_src_d = inst_bad ? RD_ZERO : RD_MEM;
        end
        if (data_en) begin
            data_src_d = data_bad ? RD_ZERO : RD_MEM;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_src_q   <= RD_ZERO;
            data_src_q   <= RD_ZERO;
            err_sticky_q <= 1'b0;
            err_count_q  <= 16'h0000;
        end else begin
            inst_src_q   <= inst_src_d;
            data_src_q   <= data_src_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    // The bank registers carry no reset; the source flag masks them to zero instead.
    assign inst_rdata = (inst_src_q == RD_MEM) ? bank_a_rdata : 32'h0000_0000;
    assign data_rdata = (data_src_q == RD_MEM) ? bank_b_rdata : 32'h0000_0000;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Self-checking bench for cpu_sram_responder against a word-array reference model.
// Each task drives one scenario and compares outputs one cycle after each access.
module tb_cpu_sram_responder;

    localparam logic [31:0] BASE      = 32'h1FC0_0000;
    localparam int unsigned MEM_BYTES = 4 * 65536;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_en;
    logic [3:0]  inst_wen;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        err_sticky;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [int unsigned];
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
    bit          exp_inst_known;
    bit          exp_data_known;
    bit          exp_sticky;
    int          exp_count;

    cpu_sram_responder dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_en    (inst_en),
        .inst_wen   (inst_wen),
        .inst_addr  (inst_addr),
        .inst_wdata (inst_wdata),
        .inst_rdata (inst_rdata),
        .data_en    (data_en),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vaddr(input int unsigned idx, input bit seg1);
        return (seg1 ? 32'hA000_0000 : 32'h8000_0000) | (BASE + idx * 4);
    endfunction

    task automatic set_inst(input logic en, input logic [3:0] wen, input logic [31:0] addr);
        inst_en = en; inst_wen = wen; inst_addr = addr; inst_wdata = $urandom;
    endtask

    task automatic set_data(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_en = en; data_wen = wen; data_addr = addr; data_wdata = wdata;
    endtask

    task automatic idle();
        set_inst(1'b0, 4'h0, $urandom);
        set_data(1'b0, 4'h0, $urandom, $urandom);
    endtask

    task automatic model_reset();
        exp_inst = 0; exp_data = 0; exp_inst_known = 1; exp_data_known = 1;
        exp_sticky = 0; exp_count = 0;
    endtask

    // Applies the access rules to the inputs present now, then advances one clock.
    task automatic step();
        int unsigned ioff, doff, nerr;
        bit il, dl;
        logic [31:0] w;
        ioff = (inst_addr & 32'h1FFF_FFFF) - BASE;
        doff = (data_addr & 32'h1FFF_FFFF) - BASE;
        il = (ioff < MEM_BYTES) && (ioff % 4 == 0) && (inst_wen == 4'h0);
        dl = (doff < MEM_BYTES) && (doff % 4 == 0);
        nerr = 0;
        if (resetn) begin
            if (inst_en) begin
                if (il) begin
                    exp_inst_known = model.exists(ioff / 4);
                    exp_inst = exp_inst_known ? model[ioff / 4] : 32'h0;
                end else begin
                    exp_inst = 0; exp_inst_known = 1; nerr++;
                end
            end
            if (data_en) begin
                if (dl) begin
                    exp_data_known = model.exists(doff / 4);
                    exp_data = exp_data_known ? model[doff / 4] : 32'h0;
                    if (data_wen != 4'h0) begin
                        w = exp_data;
                        for (int b = 0; b < 4; b++)
                            if (data_wen[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
                        model[doff / 4] = w;
                    end
                end else begin
                    exp_data = 0; exp_data_known = 1; nerr++;
                end
            end
            if (nerr != 0) exp_sticky = 1;
            exp_count = (exp_count + nerr > 65535) ? 65535 : exp_count + nerr;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (inst_rdata !== 32'h0 || data_rdata !== 32'h0 || err_sticky !== 1'b0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got inst=%h data=%h sticky=%b count=%h required all zero",
                     inst_rdata, data_rdata, err_sticky, err_count);
        end
        resetn = 1'b1;
        $display("reset: inst=%h data=%h sticky=%b count=%h", inst_rdata, data_rdata, err_sticky, err_count);
    endtask

    task automatic test_errors();
        set_data(1, 4'hF, 32'hBFC0_0040, 32'h5A5A_A5A5); step();
        set_data(1, 4'h0, 32'hBFC0_0040, 32'h0);
        set_inst(1, 4'h0, 32'h9FC0_0040); step();
        idle();
        checks++;
        if (data_rdata !== 32'h5A5A_A5A5 || inst_rdata !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL err_preload got inst=%h data=%h required 5a5aa5a5", inst_rdata, data_rdata);
        end
        set_data(1, 4'h0, BASE + MEM_BYTES, 32'h0); step(); idle();
        checks++;
        if (data_rdata !== 32'h0) begin
            errors++; $display("FAIL err_range_read got=%h required=00000000", data_rdata);
        end
        set_data(1, 4'hF, 32'hBFC0_0042, 32'hFFFF_FFFF); step(); idle();
        checks++;
        if (data_rdata !== 32'h0) begin
            errors++; $display("FAIL err_misaligned_write got=%h required=00000000", data_rdata);
        end
        set_inst(1, 4'b0001, 32'hBFC0_0040); step(); idle();
        checks++;
        if (inst_rdata !== 32'h0) begin
            errors++; $display("FAIL err_inst_wen got=%h required=00000000", inst_rdata);
        end
        checks++;
        if (err_sticky !== 1'b1 || err_count !== 16'd3) begin
            errors++;
            $display("FAIL err_counters got sticky=%b count=%0d required sticky=1 count=3", err_sticky, err_count);
        end
        set_data(1, 4'h0, 32'hBFC0_0040, 32'h0); step(); idle();
        checks++;
        if (data_rdata !== 32'h5A5A_A5A5) begin
            errors++; $display("FAIL err_array_intact got=%h required=5a5aa5a5", data_rdata);
        end
        $display("errors: sticky=%b count=%0d word=%h", err_sticky, err_count, data_rdata);
    endtask

    task automatic test_byte_lanes();
        set_data(1, 4'hF, 32'hBFC0_0010, 32'h1122_3344); step();
        set_data(1, 4'b1001, 32'hBFC0_0010, 32'hAA55_66BB); step();
        checks++;
        if (data_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL lanes_read_first got=%h required=11223344", data_rdata);
        end
        set_data(1, 4'h0, 32'h9FC0_0010, 32'h0); step(); idle();
        checks++;
        if (data_rdata !== 32'hAA22_33BB || data_rdata !== exp_data) begin
            errors++; $display("FAIL lanes_merge got=%h required=aa2233bb", data_rdata);
        end
        $display("byte_lanes: word=%h", data_rdata);
    endtask

    task automatic test_read_first();
        set_data(1, 4'hF, 32'hBFC0_0020, 32'h0BAD_F00D); step();
        set_data(1, 4'hF, 32'h9FC0_0020, 32'hDEAD_BEEF); step();
        checks++;
        if (data_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL rf_data_old got=%h required=0badf00d", data_rdata);
        end
        set_data(1, 4'h0, 32'hBFC0_0020, 32'h0); step();
        checks++;
        if (data_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rf_data_new got=%h required=deadbeef", data_rdata);
        end
        set_data(1, 4'hF, 32'hBFC0_0020, 32'hCAFE_BABE);
        set_inst(1, 4'h0, 32'h9FC0_0020); step();
        set_data(0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (inst_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rf_inst_old got=%h required=deadbeef", inst_rdata);
        end
        step(); idle();
        checks++;
        if (inst_rdata !== 32'hCAFE_BABE) begin
            errors++; $display("FAIL rf_inst_new got=%h required=cafebabe", inst_rdata);
        end
        $display("read_first: data=%h inst=%h", data_rdata, inst_rdata);
    endtask

    task automatic test_hold();
        set_data(1, 4'hF, 32'hBFC0_0030, 32'h1234_5678); step();
        set_data(1, 4'h0, 32'hBFC0_0030, 32'h0);
        set_inst(1, 4'h0, 32'hBFC0_0030); step();
        for (int c = 0; c < 5; c++) begin
            idle(); step();
            checks++;
            if (inst_rdata !== 32'h1234_5678 || data_rdata !== 32'h1234_5678) begin
                errors++;
                $display("FAIL hold_cycle%0d got inst=%h data=%h required 12345678", c, inst_rdata, data_rdata);
            end
        end
        $display("hold: inst=%h data=%h", inst_rdata, data_rdata);
    endtask

    task automatic test_random();
        int unsigned known[$];
        int unsigned idx;
        int op;
        for (int n = 0; n < 60; n++) begin
            idle();
            op = $urandom_range(0, 3);
            idx = 32'h100 + $urandom_range(0, 7);
            if (op == 1 || known.size() == 0) begin
                set_data(1, 4'hF, vaddr(idx, $urandom_range(0, 1)), $urandom);
                known.push_back(idx);
            end else if (op == 2) begin
                set_data(1, 4'($urandom_range(1, 15)), vaddr(known[$urandom_range(0, known.size()-1)],
                         $urandom_range(0, 1)), $urandom);
            end else if (op == 3) begin
                set_data(1, 4'h0, vaddr(known[$urandom_range(0, known.size()-1)], $urandom_range(0, 1)), 32'h0);
            end
            if (known.size() != 0 && $urandom_range(0, 2) != 0)
                set_inst(1, 4'h0, vaddr(known[$urandom_range(0, known.size()-1)], $urandom_range(0, 1)));
            step();
            checks++;
            if ((exp_inst_known && inst_rdata !== exp_inst) || (exp_data_known && data_rdata !== exp_data)
                || err_count !== 16'(exp_count)) begin
                errors++;
                $display("FAIL random_%0d got inst=%h data=%h count=%0d required inst=%h data=%h count=%0d",
                         n, inst_rdata, data_rdata, err_count, exp_inst, exp_data, exp_count);
            end
            $display("random %0d: inst=%h data=%h", n, inst_rdata, data_rdata);
        end
    endtask

    task automatic test_mid_reset();
        set_data(1, 4'h0, 32'hBFC0_0010, 32'h0);
        set_inst(1, 4'h0, 32'hBFC0_0030); step(); idle();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (inst_rdata !== 32'h0 || data_rdata !== 32'h0 || err_sticky !== 1'b0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got inst=%h data=%h sticky=%b count=%h required all zero",
                     inst_rdata, data_rdata, err_sticky, err_count);
        end
        set_data(1, 4'hF, 32'hBFC0_0010, 32'hFFFF_0000); step();
        resetn = 1'b1;
        set_data(1, 4'h0, 32'hBFC0_0010, 32'h0); step(); idle();
        checks++;
        if (data_rdata !== 32'hAA22_33BB) begin
            errors++; $display("FAIL reset_write_dropped got=%h required=aa2233bb", data_rdata);
        end
        $display("mid_reset: word=%h", data_rdata);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 32767; n++) begin
            set_inst(1, 4'b0001, 32'hBFC0_0000);
            set_data(1, 4'h0, 32'hBFC0_0001, 32'h0);
            step();
        end
        checks++;
        if (err_count !== 16'hFFFE || err_count !== 16'(exp_count)) begin
            errors++; $display("FAIL sat_prefill got=%h required=fffe", err_count);
        end
        step();
        checks++;
        if (err_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_dual got=%h required=ffff", err_count);
        end
        step(); idle();
        checks++;
        if (err_count !== 16'hFFFF || err_sticky !== 1'b1) begin
            errors++; $display("FAIL sat_hold got=%h sticky=%b required=ffff sticky=1", err_count, err_sticky);
        end
        $display("saturation: count=%h", err_count);
    endtask

    initial begin
        test_reset();
        test_errors();
        test_byte_lanes();
        test_read_first();
        test_hold();
        test_random();
        test_mid_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
